free_list_alloc: RTL and testbench
==================================

Name: free_list_alloc

Overview:
- Parametrised free-list allocator for the 2-issue core. It is the sequential, generalised successor to the fixed 32-to-5 encoder.
- Holds a DEPTH-entry free bitmap and offers the two lowest-index free entries per cycle as binary indices, using a priority encode rather than a one-hot OR-encode.
- Consumers take 0, 1 or 2 offered entries per cycle. Two release ports return entries to the list.
- Used for ROB/physical-register tag allocation in the rename stage.

Parameters:
- DEPTH, 32, number of tracked entries; power of two, at least 4.
- IDX_W, $clog2(DEPTH), index width; derived, do not override.
- RESERVE_ZERO, 1, when 1 entry 0 is never free: reset-cleared and never offered; a release of it is an error.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- o_alloc_vld  out  2  bit k: offer slot k holds a valid free index.
- o_alloc_idx0  out  IDX_W  lowest free index.
- o_alloc_idx1  out  IDX_W  second-lowest free index.
- i_take  in  2  bit k: consumer takes offer slot k this cycle.
- i_rel_vld  in  2  release port valids.
- i_rel_idx0  in  IDX_W  index released on port 0.
- i_rel_idx1  in  IDX_W  index released on port 1.
- o_empty  out  1  no free entries.
- o_err  out  1  sticky protocol-error flag.

Behaviour:
- State is free_q[DEPTH-1:0], where 1 means free.
- Reset (async, i_rst=1): free_q = all ones, with bit 0 cleared when RESERVE_ZERO=1. o_err = 0.
- Combinational outputs from reset state: o_alloc_vld=2'b11, o_alloc_idx0=RESERVE_ZERO, o_alloc_idx1=RESERVE_ZERO+1, o_empty=0.
- Offers are combinational from free_q only, with zero latency:
  - idx0 is the lowest set bit of free_q.
  - idx1 is the lowest set bit of free_q with bit idx0 masked.
  - When vld[k]=0, idx k is driven 0.
- o_empty = ~|free_q.
- Take rules:
  - A valid take of slot k clears free_q[idx k] at the next edge.
  - i_take[1] is honoured only together with i_take[0], which enforces in-order allocation.
  - i_take=2'b10 is ignored and sets o_err.
  - i_take[k] with o_alloc_vld[k]=0 is ignored and sets o_err.
- Release rules:
  - Each valid release sets free_q[idx] at the next edge.
  - There is no bypass: a released entry becomes offerable in the cycle after the edge.
- Release errors (release ignored, o_err set):
  - Releasing an entry that is already free in free_q.
  - Releasing entry 0 when RESERVE_ZERO=1.
  - Both ports releasing the same index in one cycle: port 0 is applied, port 1 is ignored and o_err is set.
- Same-cycle take of X and release of X cannot be legal, because an offered X is already free. It is handled by the already-free rule: the release is ignored, the take is applied, and o_err is set.
- Indices ≥ DEPTH cannot occur because DEPTH is a power of two.
- o_err clears only on reset.
- Full list (no entry allocated): all bits set and both offers valid.
- Last free entry: vld=2'b01. Taking it gives o_empty=1 at the next cycle.

Optional Feature:
- Macro: FREE_LIST_COUNT_EN.
- Defined: adds port o_free_cnt (out, IDX_W+1). It is a registered popcount of free_q, maintained incrementally as cnt + legal releases − legal takes. Reset value is DEPTH−RESERVE_ZERO. It must equal $countones(free_q) every cycle.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package free_list_pkg:
  - function clog2-safe IDX_W helper.
  - localparam error-cause encodings for debug.
  - typedef alloc_slot_t {logic vld; logic [IDX_W-1:0] idx}.
- Sub-module prio_enc_n, parametrised by N:
  - Input N-bit vector; outputs lowest-set index and a valid bit.
  - Tree-structured, so the 32-to-5 case synthesises to the same OR-tree depth.
  - Instantiated twice: once on free_q, once on the masked free_q.

Test Plan:
- Reset with DEPTH=32, RESERVE_ZERO=1 -> vld=11, idx0=1, idx1=2, o_empty=0, o_err=0 (o_free_cnt=31 if enabled).
- i_take=11 for 15 consecutive cycles -> offers advance (3,4), (5,6)…; at cycle 16 vld=01 with idx0=31. Take it -> o_empty=1, vld=00.
- Starting from empty, release 7 on port 0 and 20 on port 1 -> offers unchanged that cycle; next cycle idx0=7, idx1=20, vld=11.
- With 5 allocated, release 5 on both ports in one cycle -> 5 freed once, o_err=1 and stays 1 until i_rst.
- i_take=10 with idx0=1, idx1=2 -> free_q unchanged, o_err=1. Then i_rst pulsed mid-cycle (async) -> outputs return to reset values immediately.
- Random take/release traffic for 10k cycles against a scoreboard -> offered indices always free and lowest-first, no duplicate allocation, o_free_cnt equals the scoreboard count.

Source files
------------

// File: rtl/free_list_pkg.sv
// free_list_pkg: shared helpers, debug error-cause encodings and the offer-slot
// payload type for the free-list allocator.
//   clog2_safe()   : index width for a vector of n entries, never below 1
//   ERR_*          : bit positions of the error-cause vector inside the allocator
//   alloc_slot_t   : one allocation offer (valid + index) for the default depth
package free_list_pkg;

    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned ERR_W          = 5;
    localparam int unsigned ERR_TAKE_ORDER = 0;  // take of slot 1 without slot 0
    localparam int unsigned ERR_TAKE_NOVLD = 1;  // take of a slot that is not offered
    localparam int unsigned ERR_REL_FREE   = 2;  // release of an entry that is already free
    localparam int unsigned ERR_REL_RSVD   = 3;  // release of the reserved entry 0
    localparam int unsigned ERR_REL_DUP    = 4;  // both release ports carry the same index

    localparam int unsigned DEF_DEPTH = 32;
    localparam int unsigned DEF_IDX_W = clog2_safe(DEF_DEPTH);

    typedef struct packed {
        logic                 vld;
        logic [DEF_IDX_W-1:0] idx;
    } alloc_slot_t;

endpackage

// File: rtl/prio_enc_n.sv
// prio_enc_n: lowest-set-bit priority encoder, reduced as a balanced binary tree.
//   vec : N-bit request vector (N a power of two, at least 2)
//   vld : any bit of vec set
//   idx : index of the lowest set bit (undefined-but-deterministic when vld=0)
module prio_enc_n
    import free_list_pkg::*;
#(
    parameter  int unsigned N = 32,
    localparam int unsigned W = clog2_safe(N)
) (
    input  logic [N-1:0] vec,
    output logic         vld,
    output logic [W-1:0] idx
);

    // Each level merges node pairs in place; the left (lower) child wins and the
    // right child contributes its index with the level's bit set.
    always_comb begin : tree
        logic [N-1:0] lv;
        logic [W-1:0] lix [N];
        lv = vec;
        for (int i = 0; i < int'(N); i++) begin
            lix[i] = '0;
        end
        for (int l = 0; l < int'(W); l++) begin
            for (int j = 0; j < int'(N >> (l + 1)); j++) begin
                lix[j] = lv[2*j] ? lix[2*j] : (lix[2*j+1] | (W'(1) << l));
                lv[j]  = lv[2*j] | lv[2*j+1];
            end
        end
        vld = lv[0];
        idx = lix[0];
    end

endmodule

// File: rtl/free_list_alloc.sv
// free_list_alloc: DEPTH-entry free-list allocator offering the two lowest free
// indices per cycle, with two take slots and two release ports.
// Optional build macro FREE_LIST_COUNT_EN adds the registered free count o_free_cnt.
// Ports:
//   i_clk, i_rst            : clock (rising edge), asynchronous active-high reset
//   o_alloc_vld[1:0]        : offer slot k holds a valid free index
//   o_alloc_idx0/1          : lowest / second-lowest free index (0 when not valid)
//   i_take[1:0]             : consumer takes offer slot k this cycle
//   i_rel_vld[1:0]          : release port valids
//   i_rel_idx0/1            : released indices
//   o_empty                 : no free entries
//   o_err                   : sticky protocol-error flag
//   o_free_cnt (optional)   : number of free entries
module free_list_alloc
    import free_list_pkg::*;
#(
    parameter  int unsigned DEPTH        = 32,
    parameter  int unsigned RESERVE_ZERO = 1,
    localparam int unsigned IDX_W        = clog2_safe(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [1:0]       o_alloc_vld,
    output logic [IDX_W-1:0] o_alloc_idx0,
    output logic [IDX_W-1:0] o_alloc_idx1,
    input  logic [1:0]       i_take,
    input  logic [1:0]       i_rel_vld,
    input  logic [IDX_W-1:0] i_rel_idx0,
    input  logic [IDX_W-1:0] i_rel_idx1,
    output logic             o_empty,
`ifdef FREE_LIST_COUNT_EN
    output logic [IDX_W:0]   o_free_cnt,
`endif
    output logic             o_err
);

    localparam int unsigned      CNT_W    = IDX_W + 1;
    localparam logic             RSVD     = (RESERVE_ZERO != 0);
    localparam logic [DEPTH-1:0] FREE_RST = ~DEPTH'(RSVD);

    logic [DEPTH-1:0] free_q;
    logic [DEPTH-1:0] free_d;
    logic [DEPTH-1:0] free_masked;
    logic [DEPTH-1:0] take_mask;
    logic [DEPTH-1:0] rel_mask;
    logic             err_q;
    logic             err_d;
    logic [ERR_W-1:0] err_cause;
    logic [1:0]       take_ok;
    logic [1:0]       rel_ok;
    logic             rsvd0;
    logic             rsvd1;
    logic             rel_dup;
    logic             enc0_vld;
    logic             enc1_vld;
    logic [IDX_W-1:0] enc0_idx;
    logic [IDX_W-1:0] enc1_idx;

    // Offer 0: lowest free entry; offer 1: lowest free entry once offer 0 is removed.
    prio_enc_n #(.N(DEPTH)) u_enc0 (
        .vec (free_q),
        .vld (enc0_vld),
        .idx (enc0_idx)
    );

    assign free_masked = free_q & ~(DEPTH'(1) << enc0_idx);

    prio_enc_n #(.N(DEPTH)) u_enc1 (
        .vec (free_masked),
        .vld (enc1_vld),
        .idx (enc1_idx)
    );

    assign o_alloc_vld  = {enc1_vld, enc0_vld};
    assign o_alloc_idx0 = enc0_vld ? enc0_idx : '0;
    assign o_alloc_idx1 = enc1_vld ? enc1_idx : '0;
    assign o_empty      = ~|free_q;
    assign o_err        = err_q;

    // Legality of takes and releases, next free bitmap and error accumulation.
    always_comb begin
        err_cause = '0;
        take_ok   = '0;
        rel_ok    = '0;
        take_mask = '0;
        rel_mask  = '0;
        rsvd0     = RSVD && (i_rel_idx0 == '0);
        rsvd1     = RSVD && (i_rel_idx1 == '0);
        rel_dup   = i_rel_vld[0] & i_rel_vld[1] & (i_rel_idx0 == i_rel_idx1);

        // Slot 1 is honoured only alongside slot 0 so allocation stays in order.
        take_ok[0] = i_take[0] & enc0_vld;
        take_ok[1] = i_take[1] & i_take[0] & enc1_vld;
        err_cause[ERR_TAKE_ORDER] = (i_take == 2'b10);
        err_cause[ERR_TAKE_NOVLD] = (i_take[0] & ~enc0_vld) | (i_take[1] & ~enc1_vld);

        // An entry that is currently free cannot be released; this also covers a
        // same-cycle take and release of one index, where the take still applies.
        rel_ok[0] = i_rel_vld[0] & ~free_q[i_rel_idx0] & ~rsvd0;
        rel_ok[1] = i_rel_vld[1] & ~free_q[i_rel_idx1] & ~rsvd1 & ~rel_dup;
        err_cause[ERR_REL_FREE] = (i_rel_vld[0] & free_q[i_rel_idx0])
                                | (i_rel_vld[1] & free_q[i_rel_idx1]);
        err_cause[ERR_REL_RSVD] = (i_rel_vld[0] & rsvd0) | (i_rel_vld[1] & rsvd1);
        err_cause[ERR_REL_DUP]  = rel_dup;

        take_mask = (DEPTH'(take_ok[0]) << enc0_idx) | (DEPTH'(take_ok[1]) << enc1_idx);
        rel_mask  = (DEPTH'(rel_ok[0]) << i_rel_idx0) | (DEPTH'(rel_ok[1]) << i_rel_idx1);
        free_d    = (free_q & ~take_mask) | rel_mask;
        err_d     = err_q | (|err_cause);
    end

    // Free bitmap and sticky error flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            free_q <= FREE_RST;
            err_q  <= 1'b0;
        end else begin
            free_q <= free_d;
            err_q  <= err_d;
        end
    end

`ifdef FREE_LIST_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_RST = RSVD ? CNT_W'(DEPTH - 1) : CNT_W'(DEPTH);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Incremental popcount: legal releases add, legal takes subtract.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(rel_ok[0]) + CNT_W'(rel_ok[1])
                      - CNT_W'(take_ok[0]) - CNT_W'(take_ok[1]);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= CNT_RST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_free_cnt = cnt_q;
`else
    localparam int unsigned CNT_UNUSED = CNT_W;
`endif

endmodule

// File: tb/tb_free_list_alloc.sv
// tb_free_list_alloc: directed plus random-traffic bench for free_list_alloc
// (DEPTH=32, RESERVE_ZERO=1). Expected state comes from a behavioural bitmap
// model; post-edge expectations are queued when stimulus is driven and popped
// after the edge. Honours FREE_LIST_COUNT_EN for the o_free_cnt port.
module tb_free_list_alloc;
    import free_list_pkg::*;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned IDX_W = 5;
    localparam logic [31:0] FREE_RST = 32'hFFFF_FFFE;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       alloc_vld;
    logic [IDX_W-1:0] alloc_idx0;
    logic [IDX_W-1:0] alloc_idx1;
    logic [1:0]       take;
    logic [1:0]       rel_vld;
    logic [IDX_W-1:0] rel_idx0;
    logic [IDX_W-1:0] rel_idx1;
    logic             empty;
    logic             err;
`ifdef FREE_LIST_COUNT_EN
    logic [IDX_W:0]   free_cnt;
`endif

    always #5 clk = ~clk;

    free_list_alloc #(.DEPTH(DEPTH), .RESERVE_ZERO(1)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_alloc_vld  (alloc_vld),
        .o_alloc_idx0 (alloc_idx0),
        .o_alloc_idx1 (alloc_idx1),
        .i_take       (take),
        .i_rel_vld    (rel_vld),
        .i_rel_idx0   (rel_idx0),
        .i_rel_idx1   (rel_idx1),
        .o_empty      (empty),
`ifdef FREE_LIST_COUNT_EN
        .o_free_cnt   (free_cnt),
`endif
        .o_err        (err)
    );

    typedef struct {
        logic [1:0] vld;
        logic [4:0] i0;
        logic [4:0] i1;
        logic       empty;
        logic       err;
        int         cnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_free;
    logic        m_err;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Two lowest set bits of a bitmap, by linear scan.
    function automatic void m_offers(input logic [31:0] f, output logic [1:0] v,
                                     output logic [4:0] a, output logic [4:0] b);
        v = '0; a = '0; b = '0;
        for (int i = 0; i < 32; i++) begin
            if (f[i]) begin
                if (!v[0]) begin
                    v[0] = 1'b1; a = 5'(i);
                end else if (!v[1]) begin
                    v[1] = 1'b1; b = 5'(i);
                end
            end
        end
    endfunction

    function automatic exp_t m_expect();
        exp_t e;
        m_offers(m_free, e.vld, e.i0, e.i1);
        e.empty = (m_free == 32'h0);
        e.err   = m_err;
        e.cnt   = $countones(m_free);
        return e;
    endfunction

    task automatic m_apply(input logic [1:0] t, input logic [1:0] rv,
                           input logic [4:0] r0, input logic [4:0] r1);
        logic [1:0]  v;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [31:0] nf;
        m_offers(m_free, v, a, b);
        nf = m_free;
        if (t == 2'b10) m_err = 1'b1;
        if (t[0] && !v[0]) m_err = 1'b1;
        if (t[1] && !v[1]) m_err = 1'b1;
        if (t[0] && v[0]) nf[a] = 1'b0;
        if (t == 2'b11 && v[1]) nf[b] = 1'b0;
        if (rv[0]) begin
            if (!m_free[r0] && r0 != 5'd0) nf[r0] = 1'b1;
            else m_err = 1'b1;
        end
        if (rv[1]) begin
            if (!m_free[r1] && r1 != 5'd0 && !(rv[0] && r0 == r1)) nf[r1] = 1'b1;
            else m_err = 1'b1;
        end
        m_free = nf;
    endtask

    task automatic cmp(input string tag, input exp_t e);
        chk({tag, ".vld"},   32'(alloc_vld),  32'(e.vld));
        chk({tag, ".idx0"},  32'(alloc_idx0), 32'(e.i0));
        chk({tag, ".idx1"},  32'(alloc_idx1), 32'(e.i1));
        chk({tag, ".empty"}, 32'(empty),      32'(e.empty));
        chk({tag, ".err"},   32'(err),        32'(e.err));
`ifdef FREE_LIST_COUNT_EN
        chk({tag, ".cnt"},   32'(free_cnt),   32'(e.cnt));
`endif
    endtask

    // One clock of stimulus; called at posedge+1 and returns at the next posedge+1.
    task automatic step(input string tag, input logic [1:0] t, input logic [1:0] rv,
                        input logic [4:0] r0, input logic [4:0] r1);
        exp_t e;
        take = t; rel_vld = rv; rel_idx0 = r0; rel_idx1 = r1;
        #1;
        cmp({tag, ".pre"}, m_expect());
        m_apply(t, rv, r0, r1);
        sb.push_back(m_expect());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        cmp(tag, e);
        take = 2'b00; rel_vld = 2'b00;
    endtask

    task automatic do_reset();
        take = 2'b00; rel_vld = 2'b00; rel_idx0 = '0; rel_idx1 = '0;
        rst = 1'b1;
        #2;
        m_free = FREE_RST; m_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic int pick_alloc(input int start);
        for (int k = 0; k < 32; k++) begin
            int i;
            i = (start + k) % 32;
            if (!m_free[i] && i != 0) return i;
        end
        return -1;
    endfunction

    initial begin
        rst = 1'b1;
        take = 2'b00; rel_vld = 2'b00; rel_idx0 = '0; rel_idx1 = '0;
        m_free = FREE_RST; m_err = 1'b0;
        #3;
        chk("rst.vld",   32'(alloc_vld),  32'h3);
        chk("rst.idx0",  32'(alloc_idx0), 32'd1);
        chk("rst.idx1",  32'(alloc_idx1), 32'd2);
        chk("rst.empty", 32'(empty),      32'd0);
        chk("rst.err",   32'(err),        32'd0);
`ifdef FREE_LIST_COUNT_EN
        chk("rst.cnt",   32'(free_cnt),   32'd31);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Drain pairs until one entry remains, then take the last one.
        for (int c = 0; c < 15; c++) step("drain", 2'b11, 2'b00, 5'd0, 5'd0);
        chk("tail.vld",  32'(alloc_vld),  32'h1);
        chk("tail.idx0", 32'(alloc_idx0), 32'd31);
        step("last", 2'b01, 2'b00, 5'd0, 5'd0);
        chk("last.empty", 32'(empty),     32'd1);
        chk("last.vld",   32'(alloc_vld), 32'h0);

        // Releases appear only after the edge.
        step("rel7_20", 2'b00, 2'b11, 5'd7, 5'd20);
        chk("rel.idx0", 32'(alloc_idx0), 32'd7);
        chk("rel.idx1", 32'(alloc_idx1), 32'd20);
        chk("rel.vld",  32'(alloc_vld),  32'h3);

        // Same index on both ports: freed once, error sticks.
        step("dup5", 2'b00, 2'b11, 5'd5, 5'd5);
        chk("dup.err",  32'(err),        32'd1);
        chk("dup.idx0", 32'(alloc_idx0), 32'd5);
        chk("dup.idx1", 32'(alloc_idx1), 32'd7);
        for (int c = 0; c < 3; c++) step("sticky", 2'b00, 2'b00, 5'd0, 5'd0);
        chk("sticky.err", 32'(err), 32'd1);

        // Out-of-order take is ignored, then an async reset mid-cycle.
        do_reset();
        step("take10", 2'b10, 2'b00, 5'd0, 5'd0);
        chk("take10.idx0", 32'(alloc_idx0), 32'd1);
        chk("take10.err",  32'(err),        32'd1);
        #1;
        rst = 1'b1;
        #1;
        m_free = FREE_RST; m_err = 1'b0;
        chk("arst.err",  32'(err),        32'd0);
        chk("arst.vld",  32'(alloc_vld),  32'h3);
        chk("arst.idx0", 32'(alloc_idx0), 32'd1);
        chk("arst.idx1", 32'(alloc_idx1), 32'd2);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Same-cycle take and release of one index; release of reserved entry 0.
        step("takerel", 2'b01, 2'b01, 5'd1, 5'd0);
        chk("takerel.idx0", 32'(alloc_idx0), 32'd2);
        chk("takerel.err",  32'(err),        32'd1);
        do_reset();
        step("rel0", 2'b00, 2'b01, 5'd0, 5'd0);
        chk("rel0.err", 32'(err), 32'd1);
        do_reset();
        step("takeempty0", 2'b00, 2'b00, 5'd0, 5'd0);

        // Random legal traffic.
        for (int c = 0; c < 10000; c++) begin
            logic [1:0] mv;
            logic [4:0] ma;
            logic [4:0] mb;
            logic [1:0] t;
            logic [1:0] rv;
            int         p0;
            int         p1;
            m_offers(m_free, mv, ma, mb);
            case ($urandom_range(0, 3))
                0:       t = 2'b00;
                1:       t = 2'b01;
                default: t = 2'b11;
            endcase
            t  = t & mv;
            rv = 2'($urandom_range(0, 3));
            p0 = pick_alloc(int'($urandom_range(0, 31)));
            p1 = pick_alloc(int'($urandom_range(0, 31)));
            if (p0 < 0) rv[0] = 1'b0;
            if (p1 < 0 || (p1 == p0 && rv[0])) rv[1] = 1'b0;
            if (p0 < 0) p0 = 0;
            if (p1 < 0) p1 = 0;
            step("rand", t, rv, 5'(p0), 5'(p1));
        end
        chk("rand.err", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
